// File: rtl/key_op_arbiter_if.sv
// Handshake bundle between the key-op requesters, the arbiter and the keyboard deserializer.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface key_op_arbiter_if;
  logic        a_valid;
  logic [11:0] a_op;
  logic        a_ready;
  logic        b_valid;
  logic [11:0] b_op;
  logic        b_ready;
  logic        clr_req;
  logic        clr_busy;
  logic        key_stb;
  logic [11:0] key_op;
  logic        key_busy;
  logic        err;

  modport slave (
    input  a_valid, a_op, b_valid, b_op, clr_req, key_busy,
    output a_ready, b_ready, clr_busy, key_stb, key_op, err
  );

  modport master (
    output a_valid, a_op, b_valid, b_op, clr_req, key_busy,
    input  a_ready, b_ready, clr_busy, key_stb, key_op, err
  );
endinterface

// File: rtl/key_op_arbiter.sv
// Round-robin arbiter and release-all sequencer in front of the keyboard deserializer.
// Optional handshake watchdog and sticky ERR flag are enabled by defining KEY_ARB_TIMEOUT_EN.
module key_op_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  key_op_arbiter_if.slave bus_io
);
  typedef enum logic [1:0] {IDLE, STROBE, WAIT_DONE, RELEASE} state_e;

  state_e      state_q, state_d;
  logic [11:0] op_q, op_d;
  logic        clr_pend_q, clr_pend_d;
  logic [3:0]  step_q, step_d;
  logic        pref_b_q, pref_b_d;
  logic        active_q;
  logic        grant_a, grant_b;
  logic        timeout_hit;

  // active_q keeps READY low while reset is asserted, even though the state reads IDLE.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (active_q && (state_q == IDLE) && !clr_pend_q) begin
      if (bus_io.a_valid && (!bus_io.b_valid || !pref_b_q)) begin
        grant_a = 1'b1;
      end else if (bus_io.b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign bus_io.a_ready  = grant_a;
  assign bus_io.b_ready  = grant_b;
  assign bus_io.clr_busy = clr_pend_q;
  assign bus_io.key_stb  = (state_q == STROBE) || (state_q == WAIT_DONE);
  assign bus_io.key_op   = op_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    clr_pend_d = clr_pend_q;
    step_d     = step_q;
    pref_b_d   = pref_b_q;
    if (bus_io.clr_req) begin
      clr_pend_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        // Step counter is bumped at issue, so an aborted clear step still advances.
        if (clr_pend_q) begin
          op_d    = (step_q == 4'd8) ? 12'h8FF : {1'b0, step_q[2:0], 8'hFF};
          step_d  = step_q + 4'd1;
          state_d = STROBE;
        end else if (grant_a) begin
          op_d     = bus_io.a_op;
          pref_b_d = 1'b1;
          state_d  = STROBE;
        end else if (grant_b) begin
          op_d     = bus_io.b_op;
          pref_b_d = 1'b0;
          state_d  = STROBE;
        end
      end
      STROBE: begin
        if (timeout_hit) begin
          state_d = RELEASE;
        end else if (bus_io.key_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (timeout_hit || !bus_io.key_busy) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        if (clr_pend_q && (step_q == 4'd9)) begin
          clr_pend_d = 1'b0;
          step_d     = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      op_q       <= 12'h000;
      clr_pend_q <= 1'b0;
      step_q     <= 4'd0;
      pref_b_q   <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      clr_pend_q <= clr_pend_d;
      step_q     <= step_d;
      pref_b_q   <= pref_b_d;
      active_q   <= 1'b1;
    end
  end

`ifdef KEY_ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;
  logic       clr_start;
  logic       in_handshake;

  assign in_handshake = (state_q == STROBE) || (state_q == WAIT_DONE);
  assign timeout_hit  = in_handshake && (({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT));
  assign clr_start    = (state_q == IDLE) && clr_pend_q && (step_q == 4'd0);

  // Any state change clears the counter, which covers entry into STROBE and WAIT_DONE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        cnt_q <= 8'd0;
      end else if (in_handshake) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end else if (clr_start) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus_io.err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus_io.err  = 1'b0;
`endif
endmodule
